bomb_placer: RTL
================

BOMB_PLACER -- requirements
Module: bomb_placer

Interface
REQ-001 Parameter MAX_BOMBS, default 2, meaning max live bombs per player (range 1..7).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 i_dropA, i_dropB  input  1 each  player drop-button levels, already synchronous to clk.
REQ-005 playerAx, playerAy, playerBx, playerBy  input  4 each  player grid coordinates; legal cells are 1..8.
REQ-006 i_curBombMap_0, i_curBombMap_1  input  100 each  current bomb map, cell index 10*x+y; cell code {map_1,map_0}: 00 = empty, nonzero = bomb.
REQ-007 game_state  input  2  0 = playing; nonzero = game over.
REQ-008 i_place_ack  input  1  map owner accepts the current offer.
REQ-009 o_place_valid  output  1  placement offer pending.
REQ-010 o_place_idx  output  7  cell index 10*x+y of the offer.
REQ-011 o_place_owner  output  1  0 = player A, 1 = player B.
REQ-012 o_liveA, o_liveB  output  3 each  live-bomb counts per player.
REQ-013 o_rejA, o_rejB  output  1 each  one-cycle pulse when a drop edge is discarded.

Function
REQ-014 Drop detection SHALL be on rising edge only: level high in cycle t, low in t-1; a held button yields one request.
REQ-015 A drop edge at cycle t SHALL be accepted, setting pend_X with the latched index 10*x+y at end of t, only if all hold: game_state==0, x and y in 1..8, the cell code is 00, the owned-mask bit is clear, pend_X is clear, and live_X + pend_X + (offer owned by X) < MAX_BOMBS.
REQ-016 Any edge failing REQ-015 SHALL pulse o_rejX in cycle t+1 and change no other state.
REQ-017 The FSM states SHALL be IDLE and OFFER; it is in IDLE after reset.
REQ-018 In IDLE with any pend set, the FSM SHALL grant one pend, clear it, load o_place_idx/o_place_owner, and enter OFFER; o_place_valid SHALL be high from the next cycle, so a clean drop at cycle t yields valid at t+2.
REQ-019 When both pends are set, the grant SHALL go to the player not granted last (round-robin); last_grant resets to B, so A wins the first tie.
REQ-020 At grant time the cell SHALL be rechecked: if the cell code is nonzero or the cell is in ownA|ownB, the pend SHALL be dropped with an o_rejX pulse and the FSM SHALL stay IDLE.
REQ-021 If both pends target the same cell, only the granted one SHALL proceed; the other SHALL be rejected at its own grant by REQ-020.
REQ-022 In OFFER, o_place_valid, o_place_idx and o_place_owner SHALL hold stable until a cycle in which i_place_ack=1; at the end of that cycle the FSM SHALL set the owner's own-mask bit and return to IDLE.
REQ-023 i_place_ack while in IDLE SHALL be ignored.
REQ-024 Per cell, each player SHALL track own (100-bit) and seen (100-bit): seen sets when own=1 and the cell code is nonzero; own and seen both clear when seen=1 and the cell code is 00.
REQ-025 o_liveX SHALL equal popcount(ownX) and be registered, updating the cycle after the mask changes.
REQ-026 When game_state becomes nonzero, both pends SHALL clear without reject pulses and no new edges SHALL be accepted; an active offer SHALL still be held until ack.
REQ-027 An ack and a new drop edge in the same cycle SHALL both take effect; the count check for the new edge SHALL use values from before the ack.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL clear o_place_valid, o_place_idx, o_place_owner, o_liveA/B, o_rejA/B, pends, own/seen masks, and edge-detect history; set FSM to IDLE and last_grant to B; abandon any active offer.
REQ-029 A drop level held high across reset release SHALL NOT produce a request until it goes low and high again.

Verification
REQ-030 A at (3,4), empty map, dropA rises at t -> o_place_valid=1 at t+2, idx=34, owner=0; ack -> o_liveA=1.
REQ-031 MAX_BOMBS=2, A holds 2 live bombs, dropA edge -> o_rejA pulse, no offer; map cell 34 goes 11 then 00 -> o_liveA=1 after seen/clear; next drop is accepted.
REQ-032 dropA and dropB rise together at different cells -> A offered first; after ack B offered; the next tie goes to B.
REQ-033 A and B at the same cell (5,5), simultaneous drops -> one offer idx=55 owner A; B rejected with o_rejB pulse.
REQ-034 Offer held 5 cycles with ack=0 -> valid, idx and owner stable; rst mid-offer -> all outputs 0 next cycle; button held across reset gives no request.
REQ-035 game_state=2 with pendB set -> pendB cleared, no offer and no rejB; dropA edge -> rejA pulse.

Source files
------------

// File: rtl/bomb_placer_if.sv
// Placement offer handshake between the bomb placer and the map owner.
// The master holds valid/idx/owner stable until the slave raises ack.
interface bomb_placer_if;
    logic       o_place_valid;
    logic [6:0] o_place_idx;
    logic       o_place_owner;
    logic       i_place_ack;

    modport master (
        output o_place_valid,
        output o_place_idx,
        output o_place_owner,
        input  i_place_ack
    );

    modport slave (
        input  o_place_valid,
        input  o_place_idx,
        input  o_place_owner,
        output i_place_ack
    );
endinterface

// File: rtl/bomb_placer.sv
// Turns player drop-button edges into placement offers, one at a time, with per-player bomb limits.
// Clean drop at t gives o_place_valid at t+2; the offer is held until ack, and later drops queue one deep per player.
module bomb_placer #(
    parameter int MAX_BOMBS = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_dropA,
    input  logic         i_dropB,
    input  logic [3:0]   playerAx,
    input  logic [3:0]   playerAy,
    input  logic [3:0]   playerBx,
    input  logic [3:0]   playerBy,
    input  logic [99:0]  i_curBombMap_0,
    input  logic [99:0]  i_curBombMap_1,
    input  logic [1:0]   game_state,
    bomb_placer_if.master place,
    output logic [2:0]   o_liveA,
    output logic [2:0]   o_liveB,
    output logic         o_rejA,
    output logic         o_rejB
);

    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

    function automatic logic [6:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] t;
        t = ({4'b0, x} * 8'd10) + {4'b0, y};
        return t[6:0];
    endfunction

    function automatic logic coord_ok(input logic [3:0] v);
        return (v >= 4'd1) && (v <= 4'd8);
    endfunction

    // Indices past the grid read as occupied so they can never be offered.
    function automatic logic bit_at(input logic [99:0] v, input logic [6:0] i);
        return (i < 7'd100) ? v[i] : 1'b1;
    endfunction

    function automatic logic [6:0] popcount(input logic [99:0] v);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 0; i < 100; i++) begin
            c = c + {6'b0, v[i]};
        end
        return c;
    endfunction

    state_t      state, state_n;
    logic        prev_a, prev_b;
    logic        pend_a, pend_b;
    logic [6:0]  pend_idx_a, pend_idx_b;
    logic        last_grant;
    logic [99:0] own_a, own_b, seen_a, seen_b;
    logic [99:0] own_a_n, own_b_n, seen_a_n, seen_b_n;
    logic [99:0] occ, claimed, clr_a, clr_b;

    logic        game_ok;
    logic [6:0]  idx_a, idx_b;
    logic [6:0]  cnt_a, cnt_b;
    logic        offer_a, offer_b;
    logic        room_a, room_b;
    logic        edge_a, edge_b;
    logic        ok_a, ok_b;
    logic        try_a, try_b;
    logic [6:0]  gnt_idx;
    logic        gnt_clean;
    logic        ack_take;

    assign occ     = i_curBombMap_0 | i_curBombMap_1;
    assign claimed = own_a | own_b;
    assign game_ok = (game_state == 2'd0);
    assign idx_a   = cell_idx(playerAx, playerAy);
    assign idx_b   = cell_idx(playerBx, playerBy);
    assign edge_a  = i_dropA & ~prev_a;
    assign edge_b  = i_dropB & ~prev_b;

    // The limit uses the live mask count rather than the registered o_liveX, so the
    // cycle right after an ack (mask updated, output not yet) cannot admit an extra bomb.
    assign cnt_a   = popcount(own_a);
    assign cnt_b   = popcount(own_b);
    assign offer_a = (state == OFFER) && !place.o_place_owner;
    assign offer_b = (state == OFFER) &&  place.o_place_owner;
    assign room_a  = ({1'b0, cnt_a} + {7'b0, offer_a} + {7'b0, pend_a}) < 8'(MAX_BOMBS);
    assign room_b  = ({1'b0, cnt_b} + {7'b0, offer_b} + {7'b0, pend_b}) < 8'(MAX_BOMBS);

    assign ok_a = game_ok && coord_ok(playerAx) && coord_ok(playerAy) && !bit_at(occ, idx_a)
               && !bit_at(claimed, idx_a) && !pend_a && room_a;
    assign ok_b = game_ok && coord_ok(playerBx) && coord_ok(playerBy) && !bit_at(occ, idx_b)
               && !bit_at(claimed, idx_b) && !pend_b && room_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Arbitration lives with next-state: ties go to whoever did not win the last tie.
    always_comb begin
        try_a   = 1'b0;
        try_b   = 1'b0;
        state_n = state;
        if (state == IDLE && game_ok) begin
            if (pend_a && pend_b) begin
                try_a = last_grant;
                try_b = !last_grant;
            end else begin
                try_a = pend_a;
                try_b = pend_b;
            end
        end
        gnt_idx   = try_b ? pend_idx_b : pend_idx_a;
        gnt_clean = !bit_at(occ, gnt_idx) && !bit_at(claimed, gnt_idx);
        case (state)
            IDLE:    if ((try_a || try_b) && gnt_clean) state_n = OFFER;
            OFFER:   if (place.i_place_ack) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        place.o_place_valid = 1'b0;
        ack_take            = 1'b0;
        if (state == OFFER) begin
            place.o_place_valid = 1'b1;
            ack_take            = place.i_place_ack;
        end
    end

    // A cell is remembered as "seen" once its bomb shows on the map; when it goes
    // back to empty the bomb has exploded and the owner gets the slot back.
    always_comb begin
        clr_a    = seen_a & ~occ;
        clr_b    = seen_b & ~occ;
        own_a_n  = own_a & ~clr_a;
        own_b_n  = own_b & ~clr_b;
        seen_a_n = (seen_a | (own_a & occ)) & ~clr_a;
        seen_b_n = (seen_b | (own_b & occ)) & ~clr_b;
        if (ack_take && !place.o_place_owner) own_a_n[place.o_place_idx] = 1'b1;
        if (ack_take &&  place.o_place_owner) own_b_n[place.o_place_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // History follows the level so a button held through reset needs a fresh press.
            prev_a              <= i_dropA;
            prev_b              <= i_dropB;
            pend_a              <= 1'b0;
            pend_b              <= 1'b0;
            pend_idx_a          <= 7'd0;
            pend_idx_b          <= 7'd0;
            last_grant          <= 1'b1;
            own_a               <= '0;
            own_b               <= '0;
            seen_a              <= '0;
            seen_b              <= '0;
            place.o_place_idx   <= 7'd0;
            place.o_place_owner <= 1'b0;
            o_liveA             <= 3'd0;
            o_liveB             <= 3'd0;
            o_rejA              <= 1'b0;
            o_rejB              <= 1'b0;
        end else begin
            prev_a <= i_dropA;
            prev_b <= i_dropB;

            if (!game_ok) begin
                pend_a <= 1'b0;
            end else if (edge_a && ok_a) begin
                pend_a     <= 1'b1;
                pend_idx_a <= idx_a;
            end else if (try_a) begin
                pend_a <= 1'b0;
            end

            if (!game_ok) begin
                pend_b <= 1'b0;
            end else if (edge_b && ok_b) begin
                pend_b     <= 1'b1;
                pend_idx_b <= idx_b;
            end else if (try_b) begin
                pend_b <= 1'b0;
            end

            if (pend_a && pend_b && (try_a || try_b)) last_grant <= try_b;

            if ((try_a || try_b) && gnt_clean) begin
                place.o_place_idx   <= gnt_idx;
                place.o_place_owner <= try_b;
            end

            o_rejA <= (edge_a && !ok_a) || (try_a && !gnt_clean);
            o_rejB <= (edge_b && !ok_b) || (try_b && !gnt_clean);

            own_a   <= own_a_n;
            own_b   <= own_b_n;
            seen_a  <= seen_a_n;
            seen_b  <= seen_b_n;
            o_liveA <= cnt_a[2:0];
            o_liveB <= cnt_b[2:0];
        end
    end

endmodule
